pwm_multi: RTL
==============

Name: pwm_multi

Overview:
Multi-channel, centre-aligned (triangle-carrier) PWM generator with programmable dead time, a fault shutdown latch and shadow-register updates at carrier extremes. One shared carrier drives NCH complementary Hi/Lo output pairs, so a single instance covers a full 3-phase inverter bridge. It is the parametrised successor of the single-phase PWM block. It sits between the control-loop registers (Span/Cmp/Dead inputs) and the gate-driver pins.

Parameters:
W, 16, carrier/compare/dead-time width in bits
NCH, 3, number of complementary output channels
UPD_BOTH, 1, 1: shadow load at top and bottom; 0: bottom only
SPAN_RST, 16'hFF00, Span shadow value after reset (W bits)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
En  in  1  run enable
Span_in  in  W  carrier peak value
Cmp_in  in  NCH*W  per-channel compare, channel k at bits [k*W +: W]
Dead_in  in  W  dead-time half-width in carrier counts
Fault_in  in  1  synchronous fault request, level
FltClr  in  1  fault-latch clear request
Down  out  1  0: carrier counting up, 1: counting down
Sync  out  1  one-cycle pulse at carrier bottom
Flt  out  1  fault latched
Hi  out  NCH  high-side gate per channel
Lo  out  NCH  low-side gate per channel

Behaviour:
- Reset (async): Car=0, Down=0, Span_s=SPAN_RST, Cmp_s=all 0, Dead_s=0. Sync, Flt, Hi and Lo are all 0.
- Carrier while En=1. Up: Car+1 each cycle. At Car==Span_s with Down=0: Down<=1, Car<=Span_s-1. Down: Car-1 each cycle. At Car==0 with Down=1: Down<=0, Car<=1. Period is 2*Span_s cycles.
- Span_in values <2 load as 2.
- Shadow load:
  - Span_s, Cmp_s and Dead_s load from the inputs in the cycle Car==0 && Down==1 (bottom).
  - With UPD_BOTH=1 they also load in the cycle Car==Span_s && Down==0 (top).
  - New values take effect the following cycle. The turnaround computation in the load cycle uses the old Span_s.
- En=0: Car is forced to 0 and Down to 0. Shadows load every cycle. Hi, Lo and Sync are 0.
- En 0->1: counting starts upward from Car=0. The first Sync fires at the first return to bottom.
- Sync: registered. It is 1 in the cycle after the bottom-turnaround cycle, else 0.
- Compare, per channel k, using (W+1)-bit unsigned arithmetic so nothing overflows:
  - rawHi = (Car + Dead_s) < Cmp_s[k]
  - rawLo = Car >= (Cmp_s[k] + Dead_s)
- Hi[k] and Lo[k] are registered from rawHi and rawLo: one cycle of latency from the Car value.
  - Both are 0 across the band of 2*Dead_s counts around each crossing.
  - Hi and Lo are never 1 simultaneously, for any input values.
- Boundary cases:
  - Cmp=0: Hi is never set; Lo=1 whenever Car>=Dead_s.
  - Cmp > Span_s+Dead_s: Hi follows Car+Dead_s<Cmp. Lo is never set.
- Fault:
  - Fault_in=1 sets Flt on the next edge. In that same edge Hi and Lo are forced to 0.
  - While Flt=1, Hi and Lo stay 0. The carrier, shadows and Sync keep running.
  - FltClr=1 with Fault_in=0 clears Flt. If Fault_in and FltClr are both 1, Fault_in wins.
  - After Flt clears, outputs stay 0 until the next Sync pulse. Normal compare output resumes from the cycle after that pulse.
- Reset asserted mid-period: all state returns immediately to reset values. Operation restarts from Car=0 counting up (if En=1) after release.

Test Plan:
1. Reset mid-run -> all outputs 0 immediately. Span_s=16'hFF00 after release; Car restarts at 0.
2. Basic triangle: W=16, NCH=3, En=1, Span_in=10, Dead_in=0, Cmp=5,5,5.
   - Down toggles every 10 cycles; Sync period = 20 cycles.
   - Hi=1 (one cycle late) for Car 0..4; Lo=1 for Car 5..10.
3. Dead time: Span=10, Dead=1, Cmp ch0=5.
   - Hi=1 for Car<=3 and Lo=1 for Car>=6. Both 0 for Car 4..5, on both the up and down slopes.
   - Across 1000 cycles, Hi&Lo is never 1.
4. Shadow timing: change Cmp_in ch1 from 3 to 7 mid-up-slope.
   - UPD_BOTH=1: new duty appears after the top.
   - UPD_BOTH=0: new duty appears only after the bottom.
   - Span_in=1 runs with period 4.
5. Fault:
   - Fault_in pulse mid-period -> Hi=Lo=0 on the next edge and Flt=1.
   - FltClr together with Fault_in=1 -> Flt stays 1.
   - FltClr alone -> Flt=0, but outputs stay 0 until one cycle after the next Sync.
6. En toggle: En=0 for 5 cycles mid-slope -> Car=0, Down=0, outputs 0. Re-enable -> counting up from 0, first Sync after 2*Span_s cycles.

Source files
------------

// File: rtl/pwm_multi.sv
// Centre-aligned multi-channel PWM: one shared triangle carrier, NCH complementary
// Hi/Lo pairs with dead time, fault latch and shadow registers loaded at carrier extremes.
module pwm_multi #(
    parameter int unsigned   W        = 16,
    parameter int unsigned   NCH      = 3,
    parameter int unsigned   UPD_BOTH = 1,
    parameter logic [W-1:0]  SPAN_RST = 16'hFF00
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               En,
    input  logic [W-1:0]       Span_in,
    input  logic [NCH*W-1:0]   Cmp_in,
    input  logic [W-1:0]       Dead_in,
    input  logic               Fault_in,
    input  logic               FltClr,
    output logic               Down,
    output logic               Sync,
    output logic               Flt,
    output logic [NCH-1:0]     Hi,
    output logic [NCH-1:0]     Lo
);

    localparam logic [W-1:0]   ZERO_W  = {W{1'b0}};
    localparam logic [W-1:0]   ONE_W   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]   TWO_W   = {{(W-2){1'b0}}, 2'b10};
    localparam logic [NCH-1:0] ZERO_CH = {NCH{1'b0}};
    localparam logic           UPD_TOP = (UPD_BOTH != 32'd0);

    // A span below 2 would make the triangle degenerate, so it is raised to 2.
    function automatic logic [W-1:0] clamp_span(input logic [W-1:0] s);
        clamp_span = (s < TWO_W) ? TWO_W : s;
    endfunction

    logic [W-1:0]     car_q, car_d;
    logic             down_q, down_d;
    logic [W-1:0]     span_q, span_d;
    logic [NCH*W-1:0] cmp_q, cmp_d;
    logic [W-1:0]     dead_q, dead_d;
    logic             sync_q, sync_d;
    logic             flt_q, flt_d;
    logic             hold_q, hold_d;
    logic [NCH-1:0]   hi_q, hi_d;
    logic [NCH-1:0]   lo_q, lo_d;

    logic             at_top_s;
    logic             at_bot_s;
    logic             load_s;
    logic             out_en_s;
    logic [NCH-1:0]   raw_hi_s;
    logic [NCH-1:0]   raw_lo_s;

    assign at_top_s = En && !down_q && (car_q == span_q);
    assign at_bot_s = En && down_q && (car_q == ZERO_W);
    assign load_s   = !En || at_bot_s || (UPD_TOP && at_top_s);

    // Per-channel compare in W+1 bits so Car+Dead and Cmp+Dead cannot wrap.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [W:0] car_e_s;
        logic [W:0] cmp_e_s;
        logic [W:0] dead_e_s;
        assign car_e_s     = {1'b0, car_q};
        assign cmp_e_s     = {1'b0, cmp_q[k*W +: W]};
        assign dead_e_s    = {1'b0, dead_q};
        assign raw_hi_s[k] = (car_e_s + dead_e_s) < cmp_e_s;
        assign raw_lo_s[k] = car_e_s >= (cmp_e_s + dead_e_s);
    end

    // State register: carrier, shadows, fault latch, resume hold and gate outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            car_q  <= ZERO_W;
            down_q <= 1'b0;
            span_q <= SPAN_RST;
            cmp_q  <= {(NCH*W){1'b0}};
            dead_q <= ZERO_W;
            sync_q <= 1'b0;
            flt_q  <= 1'b0;
            hold_q <= 1'b0;
            hi_q   <= ZERO_CH;
            lo_q   <= ZERO_CH;
        end else begin
            car_q  <= car_d;
            down_q <= down_d;
            span_q <= span_d;
            cmp_q  <= cmp_d;
            dead_q <= dead_d;
            sync_q <= sync_d;
            flt_q  <= flt_d;
            hold_q <= hold_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    // Carrier next state; the turnaround uses the span in force during this cycle.
    always_comb begin
        car_d  = car_q;
        down_d = down_q;
        if (!En) begin
            car_d  = ZERO_W;
            down_d = 1'b0;
        end else if (at_top_s) begin
            car_d  = span_q - ONE_W;
            down_d = 1'b1;
        end else if (at_bot_s) begin
            car_d  = ONE_W;
            down_d = 1'b0;
        end else if (down_q) begin
            car_d  = car_q - ONE_W;
            down_d = 1'b1;
        end else begin
            car_d  = car_q + ONE_W;
            down_d = 1'b0;
        end
    end

    // Shadow registers follow the inputs only at the permitted load points.
    always_comb begin
        span_d = span_q;
        cmp_d  = cmp_q;
        dead_d = dead_q;
        if (load_s) begin
            span_d = clamp_span(Span_in);
            cmp_d  = Cmp_in;
            dead_d = Dead_in;
        end else begin
            span_d = span_q;
            cmp_d  = cmp_q;
            dead_d = dead_q;
        end
    end

    // Fault latch (set dominates clear) and post-clear hold until a Sync has been shown.
    always_comb begin
        flt_d  = flt_q;
        hold_d = hold_q;
        if (Fault_in) begin
            flt_d = 1'b1;
        end else if (FltClr) begin
            flt_d = 1'b0;
        end else begin
            flt_d = flt_q;
        end
        if (flt_q && FltClr && !Fault_in) begin
            hold_d = 1'b1;
        end else if (sync_q) begin
            hold_d = 1'b0;
        end else begin
            hold_d = hold_q;
        end
    end

    // Output stage: gates are released only when running, fault-free and not holding.
    always_comb begin
        sync_d   = at_bot_s;
        out_en_s = En && !Fault_in && !flt_q && !(hold_q && !sync_q);
        hi_d     = ZERO_CH;
        lo_d     = ZERO_CH;
        if (out_en_s) begin
            hi_d = raw_hi_s;
            lo_d = raw_lo_s & ~raw_hi_s;
        end else begin
            hi_d = ZERO_CH;
            lo_d = ZERO_CH;
        end
    end

    assign Down = down_q;
    assign Sync = sync_q;
    assign Flt  = flt_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule
